// File: rtl/alu_issue_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_pkg
// Shared types and constants for the ALU operand-issue stage.
//   - issue_state_e : issue FSM state encoding (IDLE / SETTLE / HOLD)
//   - DEF_*         : default operand width, settle time and queue depth
//   - CNT_W         : width of the settle down-counter
//   - ISSUE_CNT_W   : width of the completed-operation counter
//   - settle_load() : counter preload value for a given settle time
// ---------------------------------------------------------------------------
package alu_issue_pkg;

    localparam int unsigned DEF_WIDTH      = 32;
    localparam int unsigned DEF_SETTLE_CYC = 2;
    localparam int unsigned DEF_DEPTH      = 4;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned ISSUE_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } issue_state_e;

    // The counter is loaded on the operand-load edge and counts down to 0;
    // the edge on which it is seen at 0 samples Result. Loading cyc-1 puts
    // that sample exactly cyc edges after the load.
    function automatic logic [CNT_W-1:0] settle_load(input int unsigned cyc);
        return CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/alu_op_fifo.sv
// ---------------------------------------------------------------------------
// alu_op_fifo
// Synchronous FIFO holding queued operand pairs.
// Ports:
//   clk_i   : clock, all state on rising edge
//   srst_i  : synchronous active-high reset (empties the queue)
//   push_i  : write din_i at this edge (ignored when full)
//   pop_i   : advance the read pointer at this edge (ignored when empty)
//   din_i   : entry to write
//   dout_o  : current head entry (valid while empty_o=0)
//   full_o  : queue holds DEPTH entries
//   empty_o : queue holds no entries
// ---------------------------------------------------------------------------
module alu_op_fifo #(
    parameter int unsigned DW    = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          srst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the index bits coincide.
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [DW-1:0] mem_q [DEPTH];

    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign wr_idx  = wr_ptr_q[AW-1:0];
    assign rd_idx  = rd_ptr_q[AW-1:0];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign wr_en   = push_i && !full_o;
    assign rd_en   = pop_i && !empty_o;

    // The head is read combinationally: the issue FSM loads ArgA/ArgB on the
    // same edge it pops, so a registered read would cost a cycle of latency.
    assign dout_o = mem_q[rd_idx];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [AW-1:0] ENTRY_IDX = AW'(gi);
            always_ff @(posedge clk_i) begin
                if (wr_en && (wr_idx == ENTRY_IDX)) begin
                    mem_q[gi] <= din_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Operand issue / result capture stage around a combinational-settle ALU.
// Operand pairs are queued, driven onto ArgA/ArgB, held for SETTLE_CYC edges,
// then the ALU Result is captured and offered downstream.
// Ports:
//   Clk        : clock
//   Rst        : synchronous active-high reset
//   InValid    : upstream operand pair valid
//   InReady    : queue can accept (0 while Rst=1)
//   InA, InB   : operand pair
//   ArgA, ArgB : registered operands to the ALU
//   Result     : ALU result
//   OutValid   : OutData holds a captured result
//   OutReady   : downstream accepts the result
//   OutData    : captured result
//   Busy       : queue non-empty or an operation in flight
//   IssueCount : completed operations, wraps modulo 2^16
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int unsigned DEPTH      = DEF_DEPTH
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [WIDTH-1:0]       InA,
    input  logic [WIDTH-1:0]       InB,
    output logic [WIDTH-1:0]       ArgA,
    output logic [WIDTH-1:0]       ArgB,
    input  logic [WIDTH-1:0]       Result,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [WIDTH-1:0]       OutData,
    output logic                   Busy,
    output logic [ISSUE_CNT_W-1:0] IssueCount
);

    localparam logic [CNT_W-1:0]       SETTLE_LOAD = settle_load(SETTLE_CYC);
    localparam logic [CNT_W-1:0]       CNT_ONE     = CNT_W'(1);
    localparam logic [ISSUE_CNT_W-1:0] ISSUE_ONE   = ISSUE_CNT_W'(1);

    issue_state_e           state_q,     state_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [WIDTH-1:0]       arg_a_q,     arg_a_d;
    logic [WIDTH-1:0]       arg_b_q,     arg_b_d;
    logic [WIDTH-1:0]       out_data_q,  out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic [ISSUE_CNT_W-1:0] issue_cnt_q, issue_cnt_d;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [2*WIDTH-1:0]   fifo_dout;
    logic                 push;
    logic                 pop;

    // InReady depends only on queue occupancy and reset; a pop on the same
    // edge does not open a slot early.
    assign InReady = !fifo_full && !Rst;
    assign push    = InValid && InReady;

    alu_op_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (Clk),
        .srst_i  (Rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({InB, InA}),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        arg_a_d     = arg_a_q;
        arg_b_d     = arg_b_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        issue_cnt_d = issue_cnt_q;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    arg_a_d = fifo_dout[WIDTH-1:0];
                    arg_b_d = fifo_dout[2*WIDTH-1:WIDTH];
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    out_data_d  = Result;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_HOLD: begin
                if (OutReady) begin
                    out_valid_d = 1'b0;
                    issue_cnt_d = issue_cnt_q + ISSUE_ONE;
                    // Back-to-back: the next pair goes to the ALU on the
                    // same edge the current result is handed off.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        arg_a_d = fifo_dout[WIDTH-1:0];
                        arg_b_d = fifo_dout[2*WIDTH-1:WIDTH];
                        cnt_d   = SETTLE_LOAD;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            arg_a_q     <= '0;
            arg_b_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            arg_a_q     <= arg_a_d;
            arg_b_q     <= arg_b_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign ArgA       = arg_a_q;
    assign ArgB       = arg_b_q;
    assign OutData    = out_data_q;
    assign OutValid   = out_valid_q;
    assign IssueCount = issue_cnt_q;
    assign Busy       = !fifo_empty || (state_q != ST_IDLE);

endmodule
